// File: rtl/ser_pkg.sv
// Shared definitions for the bit serializer.
//   state_t       : FSM states (IDLE, SHIFT)
//   DEFAULT_WIDTH : default parallel word width
package ser_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

endpackage

// File: rtl/bit_serializer.sv
// Parallel-to-serial converter with a valid/ready word input.
// A word is accepted when in_valid and in_ready are both high on a rising
// edge; its bits then appear on data, one per cycle, starting the next cycle.
// A new word can be accepted on the final bit of the current one, so words
// stream with no idle gap.
//
// Ports:
//   clk        : clock, all state changes on the rising edge
//   reset      : synchronous active-high reset
//   in_data    : parallel word to serialize (WIDTH bits)
//   in_valid   : in_data holds a word to accept
//   in_ready   : block can accept a word this cycle
//   data       : serial bit stream
//   data_valid : data carries a payload bit this cycle
//   last_bit   : current bit is the final bit of its word
//   busy       : a word is being shifted out
module bit_serializer
  import ser_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             data,
  output logic             data_valid,
  output logic             last_bit,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);

  state_t           state, state_nx;
  logic [WIDTH-1:0] sreg, sreg_nx;
  logic [CW-1:0]    bit_cnt, bit_cnt_nx;
  logic             cnt_zero;
  logic             accept;
  logic [WIDTH-1:0] sreg_shifted;

  // State, shift register and bit counter
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      sreg    <= '0;
      bit_cnt <= '0;
    end else begin
      state   <= state_nx;
      sreg    <= sreg_nx;
      bit_cnt <= bit_cnt_nx;
    end
  end

  // The active end of the register always holds the bit on data, so
  // shifting moves the next bit toward that end.
  always_comb begin
    if (MSB_FIRST)
      sreg_shifted = {sreg[WIDTH-2:0], 1'b0};
    else
      sreg_shifted = {1'b0, sreg[WIDTH-1:1]};
  end

  // Next-state logic and outputs. in_ready also opens on the final bit of a
  // word so a waiting word reloads the register without leaving SHIFT.
  always_comb begin
    state_nx   = state;
    sreg_nx    = sreg;
    bit_cnt_nx = bit_cnt;
    cnt_zero   = (bit_cnt == '0);
    in_ready   = 1'b0;
    data       = 1'b0;
    data_valid = 1'b0;
    last_bit   = 1'b0;
    busy       = 1'b0;
    accept     = 1'b0;

    case (state)
      IDLE: begin
        in_ready = 1'b1;
        accept   = in_valid;
        if (accept) begin
          state_nx   = SHIFT;
          sreg_nx    = in_data;
          bit_cnt_nx = CW'(WIDTH - 1);
        end
      end

      SHIFT: begin
        in_ready   = cnt_zero;
        data       = MSB_FIRST ? sreg[WIDTH-1] : sreg[0];
        data_valid = 1'b1;
        last_bit   = cnt_zero;
        busy       = 1'b1;
        accept     = in_valid && cnt_zero;
        if (accept) begin
          sreg_nx    = in_data;
          bit_cnt_nx = CW'(WIDTH - 1);
        end else if (cnt_zero) begin
          state_nx = IDLE;
          sreg_nx  = sreg_shifted;
        end else begin
          sreg_nx    = sreg_shifted;
          bit_cnt_nx = bit_cnt - CW'(1);
        end
      end

      default: begin
        state_nx = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_bit_serializer.sv
// Directed self-checking bench for bit_serializer.
// dut_m: WIDTH=8, MSB first. dut_l: WIDTH=8, LSB first.
// Inputs are driven and outputs sampled on the falling edge.
module tb_bit_serializer;

  logic       clk;
  logic       reset;
  logic [7:0] in_data_m, in_data_l;
  logic       in_valid_m, in_valid_l;
  logic       in_ready_m, in_ready_l;
  logic       data_m, data_l;
  logic       data_valid_m, data_valid_l;
  logic       last_bit_m, last_bit_l;
  logic       busy_m, busy_l;

  int errors = 0;
  int checks = 0;

  bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_m (
    .clk        (clk),
    .reset      (reset),
    .in_data    (in_data_m),
    .in_valid   (in_valid_m),
    .in_ready   (in_ready_m),
    .data       (data_m),
    .data_valid (data_valid_m),
    .last_bit   (last_bit_m),
    .busy       (busy_m)
  );

  bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_l (
    .clk        (clk),
    .reset      (reset),
    .in_data    (in_data_l),
    .in_valid   (in_valid_l),
    .in_ready   (in_ready_l),
    .data       (data_l),
    .data_valid (data_valid_l),
    .last_bit   (last_bit_l),
    .busy       (busy_l)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Checks that dut_m shows the idle output pattern.
  task automatic check_idle_m(input string name);
    checks++;
    if ({in_ready_m, data_m, data_valid_m, last_bit_m, busy_m} !== 5'b10000) begin
      errors++;
      $display("[TB] FAIL %s: {rdy,data,dv,last,busy} got %b expected 10000", name,
               {in_ready_m, data_m, data_valid_m, last_bit_m, busy_m});
    end
  endtask

  task automatic test_reset();
    reset      = 1'b1;
    in_valid_m = 1'b0;
    in_valid_l = 1'b0;
    in_data_m  = 8'h00;
    in_data_l  = 8'h00;
    repeat (3) @(negedge clk);
    check_idle_m("reset_m");
    checks++;
    if ({in_ready_l, data_l, data_valid_l, last_bit_l, busy_l} !== 5'b10000) begin
      errors++;
      $display("[TB] FAIL reset_l: {rdy,data,dv,last,busy} got %b expected 10000",
               {in_ready_l, data_l, data_valid_l, last_bit_l, busy_l});
    end
    reset = 1'b0;
    @(negedge clk);
    check_idle_m("ready_after_reset");
  endtask

  // Sends one word on dut_m and checks all 8 bits, then the return to IDLE.
  // Also runs a 10110 detector over the emitted bits and returns its count.
  task automatic send_word_m(input logic [7:0] word, input string name, output int det);
    logic [4:0] hist;
    hist = 5'b0;
    det  = 0;
    @(negedge clk);
    in_data_m  = word;
    in_valid_m = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      in_valid_m = 1'b0;
      in_data_m  = 8'($urandom);
      checks++;
      if ({data_valid_m, busy_m, data_m} !== {1'b1, 1'b1, word[7-i]}) begin
        errors++;
        $display("[TB] FAIL %s bit%0d: {dv,busy,data} got %b expected %b", name, i,
                 {data_valid_m, busy_m, data_m}, {1'b1, 1'b1, word[7-i]});
      end
      checks++;
      if ({last_bit_m, in_ready_m} !== {2{i == 7}}) begin
        errors++;
        $display("[TB] FAIL %s last/ready%0d: got %b expected %b", name, i,
                 {last_bit_m, in_ready_m}, {2{i == 7}});
      end
      hist = {hist[3:0], data_m};
      if (hist == 5'b10110) det++;
    end
    @(negedge clk);
    check_idle_m({name, "_idle_after"});
  endtask

  task automatic test_single_word();
    int det;
    send_word_m(8'hB0, "single_B0", det);
    checks++;
    if (det !== 1) begin
      errors++;
      $display("[TB] FAIL detect_10110: got %0d expected 1", det);
    end
  endtask

  // Two words on dut_m; second word is presented (in_valid held) starting
  // after observation index hold_at and must follow with no gap.
  task automatic two_words_m(input logic [7:0] w0, input logic [7:0] w1,
                             input int hold_at, input string name);
    logic [15:0] stream;
    logic        edge_bit;
    stream = {w0, w1};
    @(negedge clk);
    in_data_m  = w0;
    in_valid_m = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      edge_bit = (i == 7) || (i == 15);
      checks++;
      if ({data_valid_m, busy_m, data_m} !== {1'b1, 1'b1, stream[15-i]}) begin
        errors++;
        $display("[TB] FAIL %s bit%0d: {dv,busy,data} got %b expected %b", name, i,
                 {data_valid_m, busy_m, data_m}, {1'b1, 1'b1, stream[15-i]});
      end
      checks++;
      if ({last_bit_m, in_ready_m} !== {2{edge_bit}}) begin
        errors++;
        $display("[TB] FAIL %s last/ready%0d: got %b expected %b", name, i,
                 {last_bit_m, in_ready_m}, {2{edge_bit}});
      end
      if (i == 0) in_valid_m = 1'b0;
      if (i == hold_at) begin
        in_valid_m = 1'b1;
        in_data_m  = w1;
      end
      if (i == 8) in_valid_m = 1'b0;
    end
    @(negedge clk);
    check_idle_m({name, "_idle_after"});
  endtask

  task automatic test_back_to_back();
    two_words_m(8'h2D, 8'h6C, 0, "b2b_2D_6C");
  endtask

  task automatic test_hold_valid();
    two_words_m(8'hB0, 8'h55, 2, "hold_B0_55");
  endtask

  task automatic test_lsb_first();
    logic [7:0] exp_bits;
    exp_bits = 8'b1011_0000;
    @(negedge clk);
    in_data_l  = 8'h0D;
    in_valid_l = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      in_valid_l = 1'b0;
      checks++;
      if ({data_valid_l, data_l, last_bit_l} !== {1'b1, exp_bits[7-i], i == 7}) begin
        errors++;
        $display("[TB] FAIL lsb_0D bit%0d: {dv,data,last} got %b expected %b", i,
                 {data_valid_l, data_l, last_bit_l}, {1'b1, exp_bits[7-i], i == 7});
      end
    end
    @(negedge clk);
    checks++;
    if ({data_valid_l, busy_l, in_ready_l} !== 3'b001) begin
      errors++;
      $display("[TB] FAIL lsb_idle_after: {dv,busy,rdy} got %b expected 001",
               {data_valid_l, busy_l, in_ready_l});
    end
  endtask

  task automatic test_reset_midword();
    int det;
    @(negedge clk);
    in_data_m  = 8'hFF;
    in_valid_m = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_valid_m = 1'b0;
    end
    checks++;
    if ({data_valid_m, data_m} !== 2'b11) begin
      errors++;
      $display("[TB] FAIL midword_bit3: {dv,data} got %b expected 11", {data_valid_m, data_m});
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_idle_m("midword_reset");
    send_word_m(8'hB0, "after_reset_B0", det);
  endtask

  task automatic test_reset_priority();
    @(negedge clk);
    in_data_m  = 8'hA5;
    in_valid_m = 1'b1;
    reset      = 1'b1;
    @(negedge clk);
    in_valid_m = 1'b0;
    reset      = 1'b0;
    check_idle_m("reset_priority");
    @(negedge clk);
    check_idle_m("reset_priority_hold");
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_back_to_back();
    test_lsb_first();
    test_reset_midword();
    test_hold_valid();
    test_reset_priority();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
